// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two valid/ready requesters; one op in flight.
// Latency: accept at edge N, response valid from N+1; the response holds and no request is taken while resp_ready is low.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_err,

    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [OPW-1:0]   alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic [31:0]      op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [OPW-1:0] OP_MIN = OPW'(1);
    localparam logic [OPW-1:0] OP_MAX = OPW'(13);

    state_t           r_state;
    logic             r_prio;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic             r_id;

    logic             r_resp_valid;
    logic             r_resp_id;
    logic [WIDTH-1:0] r_resp_result;
    logic             r_resp_zero;
    logic             r_resp_err;
    logic [31:0]      r_op_count;

    logic             w_idle;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_op_illegal;

    // Readies stay low through the reset cycle regardless of the current state.
    assign w_idle   = !reset && (r_state == S_IDLE);
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || !r_prio);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid ||  r_prio);

    assign w_op_illegal = (r_op < OP_MIN) || (r_op > OP_MAX);

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;

    assign alu_input1  = r_a;
    assign alu_input2  = r_b;
    assign alu_control = r_op;

    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_zero   = r_resp_zero;
    assign resp_err    = r_resp_err;
    assign op_count    = r_op_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_prio        <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_id          <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_resp_zero   <= 1'b0;
            r_resp_err    <= 1'b0;
            r_op_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0) begin
                        r_a     <= req0_a;
                        r_b     <= req0_b;
                        r_op    <= req0_op;
                        r_id    <= 1'b0;
                        r_prio  <= 1'b1;
                        r_state <= S_EXEC;
                    end else if (w_grant1) begin
                        r_a     <= req1_a;
                        r_b     <= req1_b;
                        r_op    <= req1_op;
                        r_id    <= 1'b1;
                        r_prio  <= 1'b0;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Illegal codes report a clean zero result whatever the ALU produced.
                    r_resp_valid  <= 1'b1;
                    r_resp_id     <= r_id;
                    r_resp_err    <= w_op_illegal;
                    r_resp_result <= w_op_illegal ? '0 : alu_result;
                    r_resp_zero   <= w_op_illegal ? 1'b1 : alu_zero;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_op_count   <= r_op_count + 32'd1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU behind the shared port.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 5;

    logic             clk;
    logic             reset;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [OPW-1:0]   req1_op;
    logic             resp_valid, resp_ready, resp_id, resp_zero, resp_err;
    logic [WIDTH-1:0] resp_result;
    logic [WIDTH-1:0] alu_input1, alu_input2, alu_result;
    logic [OPW-1:0]   alu_control;
    logic             alu_zero;
    logic [31:0]      op_count;

    int tests = 0;
    int fails = 0;

    alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .op_count(op_count)
    );

    // ALU codes: 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 LUI, 12 NOR, 13 PASSB
    always_comb begin
        case (alu_control)
            5'd1:    alu_result = alu_input1 + alu_input2;
            5'd2:    alu_result = alu_input1 - alu_input2;
            5'd3:    alu_result = alu_input1 & alu_input2;
            5'd4:    alu_result = alu_input1 | alu_input2;
            5'd5:    alu_result = alu_input1 ^ alu_input2;
            5'd6:    alu_result = alu_input1 << alu_input2[4:0];
            5'd7:    alu_result = alu_input1 >> alu_input2[4:0];
            5'd8:    alu_result = $unsigned($signed(alu_input1) >>> alu_input2[4:0]);
            5'd9:    alu_result = {31'd0, $signed(alu_input1) < $signed(alu_input2)};
            5'd10:   alu_result = {31'd0, alu_input1 < alu_input2};
            5'd11:   alu_result = alu_input2 << 16;
            5'd12:   alu_result = ~(alu_input1 | alu_input2);
            5'd13:   alu_result = alu_input2;
            default: alu_result = 32'hDEADBEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    `define CHK(tag, obs, exp) \
        begin \
            tests++; \
            assert ((obs) === (exp)) else begin \
                fails++; \
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
            end \
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(input string tag, input int max_cycles);
        int n;
        n = 0;
        while ((resp_valid !== 1'b1) && (n < max_cycles)) begin
            tick();
            n++;
        end
        tests++;
        if (resp_valid !== 1'b1) begin
            fails++;
            $error("FAIL %s: resp_valid not seen within %0d cycles", tag, max_cycles);
        end
    endtask

    initial begin
        int exp_id;

        reset = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        #1;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        tick();
        check("rst_ready_hold", 32'(req0_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_zero", 32'(resp_zero), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_op_count", op_count, 32'd0);
        check("rst_alu_control", 32'(alu_control), 32'd0);

        // Single ADD from requester 0
        reset = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 5'd1;
        #1;
        `CHK("add_ready0", req0_ready, 1'b1)
        `CHK("add_ready1", req1_ready, 1'b0)
        tick();
        req0_valid = 1'b0;
        #1;
        `CHK("add_exec_in1", alu_input1, 32'd5)
        `CHK("add_exec_in2", alu_input2, 32'd7)
        `CHK("add_exec_ctl", alu_control, 5'd1)
        `CHK("add_exec_nvalid", resp_valid, 1'b0)
        `CHK("add_exec_nready", req0_ready, 1'b0)
        tick();
        `CHK("add_valid", resp_valid, 1'b1)
        `CHK("add_result", resp_result, 32'd12)
        `CHK("add_zero", resp_zero, 1'b0)
        `CHK("add_id", resp_id, 1'b0)
        `CHK("add_err", resp_err, 1'b0)
        tick();
        `CHK("add_done_valid", resp_valid, 1'b0)
        `CHK("add_op_count", op_count, 32'd1)

        // Illegal op 0 from requester 1; the ALU model returns DEADBEEF for it
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_op = 5'd0;
        #1;
        `CHK("ill_ready1", req1_ready, 1'b1)
        tick();
        req1_valid = 1'b0;
        tick();
        `CHK("ill_err", resp_err, 1'b1)
        `CHK("ill_result", resp_result, 32'd0)
        `CHK("ill_zero", resp_zero, 1'b1)
        `CHK("ill_id", resp_id, 1'b1)
        tick();
        `CHK("ill_op_count", op_count, 32'd2)

        // Backpressure: SLT -1 < 1 held for 5 cycles with both requesters pending
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_op = 5'd9;
        tick();
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 5'd1;
        tick();
        for (int i = 0; i < 5; i++) begin
            `CHK("bp_valid", resp_valid, 1'b1)
            `CHK("bp_result", resp_result, 32'd1)
            `CHK("bp_err", resp_err, 1'b0)
            `CHK("bp_ready0", req0_ready, 1'b0)
            `CHK("bp_ready1", req1_ready, 1'b0)
            tick();
        end
        `CHK("bp_count_hold", op_count, 32'd2)
        resp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        `CHK("bp_done_valid", resp_valid, 1'b0)
        `CHK("bp_op_count", op_count, 32'd3)

        // SRA 0x80000000 by 4 from requester 1
        req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'd4; req1_op = 5'd8;
        tick();
        req1_valid = 1'b0;
        wait_resp("sra_wait", 4);
        `CHK("sra_result", resp_result, 32'hF800_0000)
        `CHK("sra_id", resp_id, 1'b1)
        tick();

        // LUI b = 0x1234 from requester 0
        req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'h1234; req0_op = 5'd11;
        tick();
        req0_valid = 1'b0;
        wait_resp("lui_wait", 4);
        `CHK("lui_result", resp_result, 32'h1234_0000)
        `CHK("lui_id", resp_id, 1'b0)
        tick();
        `CHK("lui_op_count", op_count, 32'd5)

        // Reset while a response is pending; requester 0 was granted so prio points at 1
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = 5'd1;
        tick();
        req0_a = 32'd9; req0_b = 32'd9; req0_op = 5'd2;
        req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 5'd4;
        tick();
        `CHK("rr_pre_valid", resp_valid, 1'b1)
        reset = 1'b1;
        #1;
        `CHK("rr_rst_ready0", req0_ready, 1'b0)
        `CHK("rr_rst_ready1", req1_ready, 1'b0)
        tick();
        reset = 1'b0; resp_ready = 1'b1;
        #1;
        `CHK("rr_valid", resp_valid, 1'b0)
        `CHK("rr_op_count", op_count, 32'd0)
        `CHK("rr_idle_prio0", req0_ready, 1'b1)

        // Contention: both valid continuously, grants alternate 0,1,0,1
        for (int g = 0; g < 4; g++) begin
            exp_id = g % 2;
            `CHK("ct_ready0", req0_ready, (exp_id == 0))
            `CHK("ct_ready1", req1_ready, (exp_id == 1))
            tick();
            tick();
            `CHK("ct_valid", resp_valid, 1'b1)
            `CHK("ct_id", resp_id, exp_id[0])
            `CHK("ct_result", resp_result, (exp_id == 0) ? 32'd0 : 32'hFF)
            `CHK("ct_zero", resp_zero, (exp_id == 0))
            tick();
        end
        `CHK("ct_op_count", op_count, 32'd4)

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
